// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers one instruction toward decode, applies execute redirects. Optional perf counters: FETCH_PERF_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] INC       = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        discard_reg;

  logic        ok_to_issue;
  logic        consume;
  logic [31:0] target_aligned;

  // Issue only when the buffer is empty or drains this cycle, so a response
  // always finds room.
  assign ok_to_issue    = !inst_valid || !stall;
  assign consume        = inst_valid && !stall;
  assign target_aligned = redirect_target & 32'hFFFF_FFFC;

  assign imem_req  = (state_reg == REQ) && ok_to_issue;
  assign imem_addr = pc_reg;
  assign busy      = (state_reg == WAIT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_VEC;
      discard_reg <= 1'b0;
      inst_valid  <= 1'b0;
      inst_out    <= 32'h0;
      inst_pc     <= 32'h0;
    end else if (redirect_valid) begin
      pc_reg     <= target_aligned;
      inst_valid <= 1'b0;
      case (state_reg)
        BOOT: state_reg <= REQ;
        REQ: begin
          // Request to the old pc was accepted: its response must be dropped.
          if (imem_req && imem_gnt) begin
            state_reg   <= WAIT;
            discard_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_reg   <= REQ;
            discard_reg <= 1'b0;
          end else begin
            discard_reg <= 1'b1;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end else begin
      if (consume) inst_valid <= 1'b0;
      case (state_reg)
        BOOT: state_reg <= REQ;
        REQ: begin
          if (imem_req && imem_gnt) state_reg <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_reg <= REQ;
            if (discard_reg) begin
              discard_reg <= 1'b0;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc_reg;
              inst_valid <= 1'b1;
              pc_reg     <= pc_reg + INC;
            end
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic resp_kept;
  logic resp_dropped;
  logic buf_flushed;

  assign resp_kept    = (state_reg == WAIT) && imem_rvalid && !discard_reg && !redirect_valid;
  assign resp_dropped = (state_reg == WAIT) && imem_rvalid && (discard_reg || redirect_valid);
  // A valid entry consumed on the redirect edge reached decode, so it is not a kill.
  assign buf_flushed  = redirect_valid && inst_valid && stall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_fetched <= 32'h0;
      perf_killed  <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(resp_kept);
      perf_killed  <= perf_killed + 32'(resp_dropped) + 32'(buf_flushed);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: grants push the expected instruction stream,
// a separate monitor pops and compares every instruction decode consumes.
module tb_fetch_ctrl;

  localparam logic [31:0] K      = 32'hA5A5_A5A5;
  localparam logic [31:0] RV     = 32'h0000_0000;
  localparam logic [31:0] STEP   = 32'd4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  fetch_ctrl #(.RESET_VEC(RV), .INC(STEP)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .busy(busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_killed(perf_killed)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_consumed = 0;

  // Reference model: the architectural instruction stream still expected by decode.
  logic [31:0] exp_q[$];
  logic [31:0] next_pc = RV;

  // Memory model: one outstanding request, data = addr ^ K.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 3 time units after the falling edge.
  task automatic step(input logic rv, input logic [31:0] tgt, input logic st,
                      input logic gnt_en, input logic resp_en, input int max_delay);
    @(negedge CLK);
    RESET = 1'b0;
    redirect_valid = rv;
    redirect_target = tgt;
    stall = st;
    imem_rvalid = 1'b0;
    if (mem_pend) begin
      if (mem_wait > 0) begin
        mem_wait--;
      end else if (resp_en) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_addr ^ K;
        mem_pend = 1'b0;
      end
    end
    imem_gnt = gnt_en && !mem_pend;
    #1;
    if (imem_req && imem_gnt) begin
      chk("grant_addr", imem_addr, next_pc);
      exp_q.push_back(next_pc);
      next_pc = next_pc + STEP;
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_wait = int'($urandom_range(max_delay, 0));
    end
    #2;
    if (rv) begin
      exp_q.delete();
      next_pc = tgt & 32'hFFFF_FFFC;
    end
  endtask

  task automatic do_reset(input int cycles, input logic keep_stale);
    repeat (cycles) begin
      @(negedge CLK);
      RESET = 1'b1;
      redirect_valid = 1'b0;
      stall = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      #3;
    end
    exp_q.delete();
    next_pc = RV;
    if (!keep_stale) mem_pend = 1'b0;
  endtask

  // Monitor: decides just before each rising edge whether decode consumes.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (!RESET && inst_valid === 1'b1 && stall === 1'b0) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL consume_unexpected: got pc %h, expected no instruction", inst_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst_out", inst_out, e ^ K);
          $display("consume pc=%h inst=%h", inst_pc, inst_out);
        end
      end
    end
  end

  initial begin
    int base;

    // Reset state
    do_reset(2, 1'b0);
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst_out, 32'h0);
    chk("reset_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset_perf_fetched", perf_fetched, 32'h0);
    chk("reset_perf_killed", perf_killed, 32'h0);
`endif

    // Zero-wait sequential fetch: one instruction per two cycles
    base = n_consumed;
    repeat (11) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    chk("seq_count", 32'(n_consumed - base), 32'd4);

    // Stall holds the buffer and blocks new requests
    repeat (5) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 0);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", inst_pc, 32'h10);
      chk("stall_inst", inst_out, 32'h10 ^ K);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h14);

    // Redirect while waiting: pending response is dropped
    step(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 0);
    chk("redir_wait_busy", 32'(busy), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    chk("redir_wait_busy2", 32'(busy), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    chk("redir_wait_valid", 32'(inst_valid), 32'd0);
    chk("redir_wait_addr", imem_addr, 32'h100);
    chk("redir_wait_req", 32'(imem_req), 32'd1);

    // Redirect coincident with grant at pc 0x8
    do_reset(2, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 0);
    chk("coinc_old_addr", imem_addr, 32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    chk("coinc_valid", 32'(inst_valid), 32'd0);
    chk("coinc_addr", imem_addr, 32'h40);
    chk("coinc_req", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_EN
    chk("coinc_perf_killed", perf_killed, 32'd1);
    chk("coinc_perf_fetched", perf_fetched, 32'd2);
`endif

    // Wrap at the top of the address space; low target bits ignored
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_valid0", 32'(inst_valid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    chk("wrap_pc1", inst_pc, 32'h0);
    chk("wrap_inst1", inst_out, K);

    // Reset mid-WAIT; the stale response arrives afterwards and is ignored
    do_reset(2, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    chk("rst_boot_req", 32'(imem_req), 32'd0);
    chk("rst_boot_busy", 32'(busy), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_req", 32'(imem_req), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    chk("rst_first_valid", 32'(inst_valid), 32'd1);
    chk("rst_first_pc", inst_pc, RV);

    // Randomized traffic against the model
    repeat (2000) begin
      if ($urandom_range(199, 0) == 0) begin
        do_reset(int'($urandom_range(2, 1)), 1'b0);
      end else begin
        logic        rv;
        logic [31:0] tgt;
        rv  = ($urandom_range(15, 0) == 0);
        tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
        step(rv, tgt, $urandom_range(2, 0) == 0, $urandom_range(2, 0) != 0,
             $urandom_range(3, 0) != 0, 2);
      end
    end
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
